// File: rtl/inst_buffer_ctrl.sv
// inst_buffer_ctrl: head/tail/occupancy sequencing for the
// decode-to-dispatch instruction buffer, with flush recovery.
module inst_buffer_ctrl #(
  parameter int DEPTH          = 32,
  parameter int DEPTH_LOG      = 5,
  parameter int FETCH_BW       = 8,
  parameter int DISPATCH_WIDTH = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 stall_i,
  input  logic                 decodeReady_i,
  input  logic [FETCH_BW-1:0]  decodedVector_i,
  output logic [FETCH_BW-1:0]  writeEnable_o,
  output logic [DEPTH_LOG-1:0] writeBase_o,
  output logic [DEPTH_LOG-1:0] readBase_o,
  output logic                 dispatchValid_o,
  output logic                 stallFetch_o,
  output logic [DEPTH_LOG:0]   instCount_o,
  output logic                 bufferReset_o,
  output logic                 protocolErr_o,
  output logic [1:0]           state_o
);

  localparam int RC_W =
    (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_INIT =
    RC_W'(RECOVER_CYCLES - 1);
  localparam logic [RC_W-1:0] RC_ONE = RC_W'(1);
  localparam logic [DEPTH_LOG:0] FULL_TH =
    (DEPTH_LOG+1)'(DEPTH - FETCH_BW);
  localparam logic [DEPTH_LOG:0] DISP_N =
    (DEPTH_LOG+1)'(DISPATCH_WIDTH);
  localparam logic [FETCH_BW-1:0] VEC_ONE = FETCH_BW'(1);

  typedef enum logic [1:0] {
    RECOVER = 2'd0,
    RUN     = 2'd1
  } state_t;

  state_t               state;
  state_t               stateNext;
  logic [RC_W-1:0]      recoverCnt;
  logic [RC_W-1:0]      recoverCntNext;
  logic [DEPTH_LOG-1:0] head;
  logic [DEPTH_LOG-1:0] headNext;
  logic [DEPTH_LOG-1:0] tail;
  logic [DEPTH_LOG-1:0] tailNext;
  logic [DEPTH_LOG:0]   count;
  logic [DEPTH_LOG:0]   countNext;
  logic                 protocolErr;
  logic                 protocolErrNext;

  logic                 accept;
  logic                 contiguous;
  logic [FETCH_BW-1:0]  vecPlusOne;
  logic [DEPTH_LOG:0]   wrCnt;
  logic [DEPTH_LOG:0]   rdCnt;

  assign bufferReset_o = (state == RECOVER);
  assign stallFetch_o  = (state != RUN) | (count > FULL_TH);
  assign accept        = decodeReady_i & ~stallFetch_o & ~flush_i;
  assign writeEnable_o = accept ? decodedVector_i : '0;

  // Dispatch looks only at registered occupancy; no same-cycle bypass.
  assign dispatchValid_o = (state == RUN) & ~stall_i & ~flush_i &
                           (count >= DISP_N);
  assign rdCnt = dispatchValid_o ? DISP_N : '0;

  // A vector filled from bit 0 has no carry escaping past its top one.
  assign vecPlusOne = decodedVector_i + VEC_ONE;
  assign contiguous = ~|(decodedVector_i & vecPlusOne);

  assign writeBase_o   = tail;
  assign readBase_o    = head;
  assign instCount_o   = count;
  assign protocolErr_o = protocolErr;
  assign state_o       = state;

  always_comb begin
    wrCnt = '0;
    for (int k = 0; k < FETCH_BW; k++) begin
      wrCnt = wrCnt + {{DEPTH_LOG{1'b0}}, writeEnable_o[k]};
    end
  end

  always_comb begin
    stateNext       = state;
    recoverCntNext  = recoverCnt;
    headNext        = head;
    tailNext        = tail;
    countNext       = count;
    protocolErrNext = protocolErr | (accept & ~contiguous);
    if (flush_i) begin
      stateNext      = RECOVER;
      recoverCntNext = RC_INIT;
      headNext       = '0;
      tailNext       = '0;
      countNext      = '0;
    end else begin
      unique case (state)
        RECOVER: begin
          if (recoverCnt == '0) begin
            stateNext = RUN;
          end else begin
            recoverCntNext = recoverCnt - RC_ONE;
          end
        end
        RUN: begin
          tailNext  = tail + wrCnt[DEPTH_LOG-1:0];
          headNext  = head + rdCnt[DEPTH_LOG-1:0];
          countNext = count + wrCnt - rdCnt;
        end
        default: begin
          stateNext      = RECOVER;
          recoverCntNext = RC_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RECOVER;
      recoverCnt  <= RC_INIT;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      protocolErr <= 1'b0;
    end else begin
      state       <= stateNext;
      recoverCnt  <= recoverCntNext;
      head        <= headNext;
      tail        <= tailNext;
      count       <= countNext;
      protocolErr <= protocolErrNext;
    end
  end

endmodule

// File: tb/tb_inst_buffer_ctrl.sv
// tb_inst_buffer_ctrl: directed scenarios plus randomized traffic
// against an occupancy/pointer reference model.
module tb_inst_buffer_ctrl;

  localparam int DEPTH = 32;
  localparam int FB    = 8;
  localparam int DW    = 4;
  localparam int RC    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       stall;
  logic       ready;
  logic [7:0] vec;
  logic [7:0] writeEnable;
  logic [4:0] writeBase;
  logic [4:0] readBase;
  logic       dispatchValid;
  logic       stallFetch;
  logic [5:0] instCount;
  logic       bufferReset;
  logic       protocolErr;
  logic [1:0] state;

  int nChecks = 0;
  int nPass   = 0;

  int mCount;
  int mHead;
  int mTail;
  int mRecLeft;
  bit mErr;

  inst_buffer_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .flush_i         (flush),
    .stall_i         (stall),
    .decodeReady_i   (ready),
    .decodedVector_i (vec),
    .writeEnable_o   (writeEnable),
    .writeBase_o     (writeBase),
    .readBase_o      (readBase),
    .dispatchValid_o (dispatchValid),
    .stallFetch_o    (stallFetch),
    .instCount_o     (instCount),
    .bufferReset_o   (bufferReset),
    .protocolErr_o   (protocolErr),
    .state_o         (state)
  );

  always #5 clk = ~clk;

  function automatic bit expStall();
    return (mRecLeft != 0) || (mCount > DEPTH - FB);
  endfunction

  function automatic logic [7:0] expWe();
    if (ready && !expStall() && !flush) return vec;
    return 8'h00;
  endfunction

  function automatic bit expDv();
    return (mRecLeft == 0) && !stall && !flush && (mCount >= DW);
  endfunction

  task automatic setIn(input bit r, input bit f, input bit s,
                       input bit rd, input logic [7:0] v);
    reset = r;
    flush = f;
    stall = s;
    ready = rd;
    vec   = v;
  endtask

  task automatic tick();
    logic [7:0] we;
    bit         dv;
    int         n;
    we = expWe();
    dv = expDv();
    n  = $countones(we);
    @(posedge clk);
    if (reset || flush) begin
      mCount   = 0;
      mHead    = 0;
      mTail    = 0;
      mRecLeft = RC;
      if (reset) mErr = 0;
    end else if (mRecLeft != 0) begin
      mRecLeft--;
    end else begin
      if (int'(we) != (1 << n) - 1) mErr = 1;
      mTail  = (mTail + n) % DEPTH;
      if (dv) mHead = (mHead + DW) % DEPTH;
      mCount = mCount + n - (dv ? DW : 0);
    end
    #1;
  endtask

  task automatic test_reset();
    setIn(1, 0, 0, 1, 8'hFF);
    tick();
    @(negedge clk);
    nChecks++;
    if ({writeEnable, dispatchValid, stallFetch, bufferReset,
         instCount, protocolErr} !== {8'h00, 1'b0, 1'b1, 1'b1,
                                      6'd0, 1'b0})
      $display("FAIL reset_vals: we=%h dv=%b sf=%b br=%b cnt=%0d pe=%b",
               writeEnable, dispatchValid, stallFetch, bufferReset,
               instCount, protocolErr);
    else nPass++;
    tick();
    setIn(0, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      nChecks++;
      if (i < 3 && {state, bufferReset, stallFetch} !== 4'b0011)
        $display("FAIL reset_recover c%0d: st=%0d br=%b sf=%b want 0 1 1",
                 i, state, bufferReset, stallFetch);
      else if (i == 3 &&
               {state, stallFetch, instCount} !== {2'd1, 1'b0, 6'd0})
        $display("FAIL reset_run: st=%0d sf=%b cnt=%0d want 1 0 0",
                 state, stallFetch, instCount);
      else nPass++;
      tick();
    end
  endtask

  task automatic test_fill();
    setIn(0, 0, 1, 1, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nChecks++;
      if (writeBase !== 5'(8 * i) || writeEnable !== 8'hFF ||
          instCount !== 6'(8 * i))
        $display("FAIL fill%0d: wb=%0d we=%h cnt=%0d want %0d ff %0d",
                 i, writeBase, writeEnable, instCount, 8 * i, 8 * i);
      else nPass++;
      tick();
    end
    @(negedge clk);
    nChecks++;
    if ({instCount, writeBase, stallFetch, writeEnable} !==
        {6'd32, 5'd0, 1'b1, 8'h00})
      $display("FAIL fill_full: cnt=%0d wb=%0d sf=%b we=%h want 32 0 1 00",
               instCount, writeBase, stallFetch, writeEnable);
    else nPass++;
    tick();
  endtask

  task automatic test_drain();
    setIn(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      nChecks++;
      if (dispatchValid !== 1'b1 || readBase !== 5'(4 * i) ||
          instCount !== 6'(32 - 4 * i))
        $display("FAIL drain%0d: dv=%b rb=%0d cnt=%0d want 1 %0d %0d",
                 i, dispatchValid, readBase, instCount, 4 * i, 32 - 4 * i);
      else nPass++;
      tick();
    end
    @(negedge clk);
    nChecks++;
    if ({dispatchValid, readBase, instCount} !== {1'b0, 5'd0, 6'd0})
      $display("FAIL drain_empty: dv=%b rb=%0d cnt=%0d want 0 0 0",
               dispatchValid, readBase, instCount);
    else nPass++;
    tick();
  endtask

  task automatic test_steady();
    setIn(0, 0, 0, 1, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nChecks++;
      if (instCount !== 6'((i == 0) ? 0 : 4) ||
          dispatchValid !== (i != 0) || writeEnable !== 8'h0F)
        $display("FAIL steady%0d: cnt=%0d dv=%b we=%h want %0d %b 0f",
                 i, instCount, dispatchValid, writeEnable,
                 (i == 0) ? 0 : 4, i != 0);
      else nPass++;
      tick();
    end
    setIn(0, 0, 0, 0, 8'h00);
    tick();
    setIn(0, 0, 0, 1, 8'h07);
    tick();
    setIn(0, 0, 0, 0, 8'h00);
    @(negedge clk);
    nChecks++;
    if (instCount !== 6'd3 || dispatchValid !== 1'b0)
      $display("FAIL partial: cnt=%0d dv=%b want 3 0",
               instCount, dispatchValid);
    else nPass++;
    tick();
  endtask

  task automatic test_flush();
    while (mCount < 20) begin
      setIn(0, 0, 1, 1,
            (20 - mCount >= 8) ? 8'hFF : 8'((1 << (20 - mCount)) - 1));
      tick();
    end
    setIn(0, 1, 0, 1, 8'hFF);
    @(negedge clk);
    nChecks++;
    if ({instCount, writeEnable, dispatchValid} !==
        {6'd20, 8'h00, 1'b0})
      $display("FAIL flush_cycle: cnt=%0d we=%h dv=%b want 20 00 0",
               instCount, writeEnable, dispatchValid);
    else nPass++;
    tick();
    setIn(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nChecks++;
      if (state !== 2'((i == 2) ? 1 : 0) || instCount !== 6'd0 ||
          readBase !== 5'd0 || writeBase !== 5'd0)
        $display("FAIL flush_rec%0d: st=%0d cnt=%0d rb=%0d wb=%0d",
                 i, state, instCount, readBase, writeBase);
      else nPass++;
      tick();
    end
    setIn(0, 1, 0, 0, 8'h00);
    tick();
    for (int i = 0; i < 4; i++) begin
      setIn(0, i == 0, 0, 0, 8'h00);
      @(negedge clk);
      nChecks++;
      if (state !== 2'((i == 3) ? 1 : 0))
        $display("FAIL reflush%0d: st=%0d want %0d",
                 i, state, (i == 3) ? 1 : 0);
      else nPass++;
      tick();
    end
  endtask

  task automatic test_protocol();
    setIn(0, 0, 1, 1, 8'h05);
    tick();
    setIn(0, 0, 1, 0, 8'h00);
    @(negedge clk);
    nChecks++;
    if (instCount !== 6'd2 || protocolErr !== 1'b1)
      $display("FAIL proto_set: cnt=%0d pe=%b want 2 1",
               instCount, protocolErr);
    else nPass++;
    setIn(0, 1, 0, 0, 8'h00);
    tick();
    setIn(0, 0, 0, 0, 8'h00);
    tick();
    tick();
    @(negedge clk);
    nChecks++;
    if (protocolErr !== 1'b1 || state !== 2'd1)
      $display("FAIL proto_flush: pe=%b st=%0d want 1 1",
               protocolErr, state);
    else nPass++;
    setIn(1, 0, 0, 0, 8'h00);
    tick();
    setIn(0, 0, 0, 0, 8'h00);
    @(negedge clk);
    nChecks++;
    if (protocolErr !== 1'b0)
      $display("FAIL proto_reset: pe=%b want 0", protocolErr);
    else nPass++;
    tick();
    tick();
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      setIn($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
            (r < 9) ? 8'((1 << r) - 1) : 8'($urandom));
      @(negedge clk);
      if (!reset) begin
        nChecks++;
        if (writeEnable !== expWe() || dispatchValid !== expDv() ||
            stallFetch !== expStall() || instCount !== 6'(mCount) ||
            writeBase !== 5'(mTail) || readBase !== 5'(mHead) ||
            bufferReset !== (mRecLeft != 0) ||
            state !== 2'((mRecLeft == 0) ? 1 : 0) ||
            protocolErr !== mErr)
          $display("FAIL rand%0d: we=%h/%h dv=%b/%b sf=%b/%b cnt=%0d/%0d wb=%0d/%0d rb=%0d/%0d st=%0d pe=%b/%b",
                   i, writeEnable, expWe(), dispatchValid, expDv(),
                   stallFetch, expStall(), instCount, mCount,
                   writeBase, mTail, readBase, mHead, state,
                   protocolErr, mErr);
        else nPass++;
      end
      tick();
    end
  endtask

  initial begin
    setIn(1, 0, 0, 0, 8'h00);
    test_reset();
    test_fill();
    test_drain();
    test_steady();
    test_flush();
    test_protocol();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
